// File: rtl/slave_serial_port.sv
// Slave serial endpoint: deserializes bus requests into register-file reads/writes and returns an ack/data frame.
// Latency: response start bit TURN+1 cycles after the request stop bit; no backpressure, busy=1 at stop yields a nack.
module slave_serial_port #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int TURN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    input  logic              busy,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] waddr,
    output logic              wvalid,
    output logic              frame_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        IDLE, RX_RW, RX_ADDR, RX_DATA, RX_STOP,
        TURN_WAIT, TX_START, TX_ACK, TX_DATA, TX_STOP
    } state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw, r_ack;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data, r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               r_tx, w_tx_next;
    logic [DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_wvalid, r_ferr;

    assign tx        = r_tx;
    assign wdata     = r_wdata;
    assign waddr     = r_waddr;
    assign wvalid    = r_wvalid;
    assign frame_err = r_ferr;

    // w_tx_next is the bit the *next* state emits, so registered tx lines up with the state.
    always_comb begin
        w_next    = r_state;
        w_tx_next = 1'b1;
        unique case (r_state)
            IDLE:      if (!rx) w_next = RX_RW;
            RX_RW:     w_next = RX_ADDR;
            RX_ADDR:   if (r_cnt == CNT_W'(ADDR_W - 1)) w_next = r_rw ? RX_DATA : RX_STOP;
            RX_DATA:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next = RX_STOP;
            RX_STOP:   w_next = rx ? TURN_WAIT : IDLE;
            TURN_WAIT: begin
                if (r_cnt == CNT_W'(TURN - 1)) begin
                    w_next    = TX_START;
                    w_tx_next = 1'b0;
                end
            end
            TX_START: begin
                w_next    = TX_ACK;
                w_tx_next = r_ack;
            end
            TX_ACK: begin
                if (!r_rw && r_ack) begin
                    w_next    = TX_DATA;
                    w_tx_next = r_rdata[0];
                end else begin
                    w_next = TX_STOP;
                end
            end
            TX_DATA: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) w_next = TX_STOP;
                else                             w_tx_next = r_rdata[1];
            end
            TX_STOP:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
            r_ack    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
            r_tx     <= 1'b1;
            r_wdata  <= '0;
            r_waddr  <= '0;
            r_wvalid <= 1'b0;
            r_ferr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state  <= w_next;
            r_tx     <= w_tx_next;
            r_wvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_cnt    <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            unique case (r_state)
                RX_RW:   r_rw   <= rx;
                RX_ADDR: r_addr <= {rx, r_addr[ADDR_W-1:1]};
                RX_DATA: r_data <= {rx, r_data[DATA_W-1:1]};
                RX_STOP: begin
                    if (!rx) begin
                        r_ferr <= 1'b1;
                    end else begin
                        // Read data is snapshotted here so the response reflects this frame's view.
                        r_ack   <= ~busy;
                        r_rdata <= r_mem[r_addr];
                        if (r_rw && !busy) begin
                            r_mem[r_addr] <= r_data;
                            r_wdata       <= r_data;
                            r_waddr       <= r_addr;
                            r_wvalid      <= 1'b1;
                        end
                    end
                end
                TX_DATA: r_rdata <= r_rdata >> 1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_serial_port.sv
// Directed bench for slave_serial_port: a byte-array model predicts each response, which is queued
// when the request is driven and popped when the response frame is sampled.
module tb_slave_serial_port;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int TURN   = 2;

    logic              clk = 1'b0;
    logic              rst, rx, busy;
    logic              tx, wvalid, frame_err;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] waddr;

    typedef struct packed {
        logic              ack;
        logic              has_data;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             exp_q[$];
    logic [DATA_W-1:0] model [2**ADDR_W];
    int                n_tests = 0;
    int                n_fail  = 0;

    slave_serial_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TURN(TURN)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .busy(busy),
        .wdata(wdata), .waddr(waddr), .wvalid(wvalid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
    endtask

    // Drives one request frame; returns during the cycle after the stop bit.
    task automatic send_req(input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic bsy, input logic stop);
        resp_t e;
        e.ack      = ~bsy;
        e.has_data = !rw && !bsy;
        e.data     = model[addr];
        if (stop) begin
            exp_q.push_back(e);
            if (rw && !bsy) model[addr] = data;
        end
        rx = 1'b0; step();
        rx = rw;   step();
        for (int i = 0; i < ADDR_W; i++) begin rx = addr[i]; step(); end
        if (rw) for (int i = 0; i < DATA_W; i++) begin rx = data[i]; step(); end
        rx = stop; busy = bsy;
        step();
        rx = 1'b1; busy = 1'b0;
        if (!stop) begin
            chk("frame_err_pulse", {31'd0, frame_err}, 32'd1);
            chk("ferr_no_wvalid", {31'd0, wvalid}, 32'd0);
        end else begin
            chk("no_frame_err", {31'd0, frame_err}, 32'd0);
            chk("wvalid", {31'd0, wvalid}, {31'd0, rw && !bsy});
            if (rw && !bsy) begin
                chk("wdata", {24'd0, wdata}, {24'd0, data});
                chk("waddr", {28'd0, waddr}, {28'd0, addr});
            end
        end
    endtask

    // Checks a full response; returns on the first IDLE cycle after the stop bit.
    task automatic get_resp(input string tag);
        resp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < TURN; i++) begin
            chk({tag, "_turn"}, {31'd0, tx}, 32'd1);
            step();
            if (i == 0) chk({tag, "_wvalid_1cyc"}, {31'd0, wvalid}, 32'd0);
        end
        chk({tag, "_start"}, {31'd0, tx}, 32'd0); step();
        chk({tag, "_ack"}, {31'd0, tx}, {31'd0, e.ack}); step();
        if (e.has_data)
            for (int i = 0; i < DATA_W; i++) begin
                chk({tag, "_data"}, {31'd0, tx}, {31'd0, e.data[i]});
                step();
            end
        chk({tag, "_stop"}, {31'd0, tx}, 32'd1); step();
    endtask

    initial begin
        resp_t e;
        rst = 1'b1; rx = 1'b1; busy = 1'b0;
        clear_model();
        step(); step(); step();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 2**ADDR_W; a++) begin
            send_req(1'b0, ADDR_W'(a), '0, 1'b0, 1'b1);
            get_resp("rd_reset");
        end

        send_req(1'b1, 4'h5, 8'hA7, 1'b0, 1'b1);
        get_resp("wr_a7");
        send_req(1'b0, 4'h5, '0, 1'b0, 1'b1);
        get_resp("rd_a7");

        send_req(1'b1, 4'h3, 8'h11, 1'b1, 1'b1);
        get_resp("wr_busy");
        send_req(1'b0, 4'h3, '0, 1'b0, 1'b1);
        get_resp("rd_after_nack");
        send_req(1'b0, 4'h5, '0, 1'b1, 1'b1);
        get_resp("rd_busy");

        send_req(1'b1, 4'h9, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < TURN + 4; i++) begin
            chk("ferr_tx_idle", {31'd0, tx}, 32'd1);
            step();
            if (i == 0) chk("ferr_pulse_1cyc", {31'd0, frame_err}, 32'd0);
        end
        send_req(1'b0, 4'h9, '0, 1'b0, 1'b1);
        get_resp("rd_after_ferr");
        send_req(1'b1, 4'hF, 8'h5A, 1'b0, 1'b1);
        get_resp("wr_5a");
        send_req(1'b0, 4'hF, '0, 1'b0, 1'b1);
        get_resp("rd_5a");

        // Abort a read mid-data with reset, then start a frame on the very next cycle.
        send_req(1'b0, 4'h5, '0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        for (int i = 0; i < TURN; i++) step();
        chk("abort_start", {31'd0, tx}, 32'd0); step();
        chk("abort_ack", {31'd0, tx}, 32'd1); step();
        for (int i = 0; i < 3; i++) begin
            chk("abort_data", {31'd0, tx}, {31'd0, e.data[i]});
            step();
        end
        rst = 1'b1;
        step();
        chk("abort_rst_tx", {31'd0, tx}, 32'd1);
        chk("abort_rst_wdata", {24'd0, wdata}, 32'd0);
        rst = 1'b0;
        clear_model();
        send_req(1'b0, 4'h5, '0, 1'b0, 1'b1);
        get_resp("rd_after_rst");
        send_req(1'b0, 4'hF, '0, 1'b0, 1'b1);
        get_resp("rd_after_rst_f");

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
